// File: rtl/dda_host_pkg.sv
// Shared constants and state types for the DDA host byte interface.
package dda_host_pkg;

  // Command opcodes carried in bits [7:4] of a command byte.
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_RUN   = 4'h2;
  localparam logic [3:0] OP_STOP  = 4'h3;
  localparam logic [3:0] OP_SNAP  = 4'h4;

  // Configuration register indices carried in bits [2:0] of a WRITE command.
  localparam logic [2:0] REG_IC1 = 3'd0;
  localparam logic [2:0] REG_IC2 = 3'd1;
  localparam logic [2:0] REG_VKM = 3'd2;
  localparam logic [2:0] REG_VDM = 3'd3;
  localparam logic [2:0] REG_DT  = 3'd4;
  localparam int         NUM_CFG = 5;

  // Command parser states.
  typedef enum logic [1:0] {
    P_CMD,
    P_WDATA,
    P_PDATA
  } parse_state_t;

  // Run engine states.
  typedef enum logic [2:0] {
    R_IDLE,
    R_LOAD,
    R_CAP,
    R_SEND,
    R_WAIT,
    R_STEP
  } run_state_t;

endpackage

// File: rtl/dda_tx_ser.sv
// Frame serializer: holds one {v1,v2} frame and emits it MSB byte first
// over a valid/ready handshake. done pulses with the final byte handshake.
module dda_tx_ser
  import dda_host_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [2*N-1:0] frame,
  input  logic           tx_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  output logic           done
);

  localparam int NB = 2 * (N / 8);
  localparam int CW = $clog2(NB) + 1;

  logic [2*N-1:0] shift_reg, shift_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           valid_reg, valid_next;

  assign tx_data  = shift_reg[2*N-1 -: 8];
  assign tx_valid = valid_reg;

  // Shift register state; a partial frame is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
    end
  end

  // Load a new frame, or advance one byte per accepted handshake.
  always_comb begin
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    done       = 1'b0;
    if (load) begin
      shift_next = frame;
      cnt_next   = '0;
      valid_next = 1'b1;
    end else if (valid_reg && tx_ready) begin
      shift_next = shift_reg << 8;
      if (cnt_reg == CW'(NB - 1)) begin
        valid_next = 1'b0;
        done       = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dda_host_if.sv
// Host byte interface for the posit DDA core: parses commands into the
// configuration registers, sequences load/step strobes at a programmable
// period and streams every (v1,v2) sample back to the host.
module dda_host_if
  import dda_host_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [N-1:0] ic1,
  output logic [N-1:0] ic2,
  output logic [N-1:0] vk_m,
  output logic [N-1:0] vd_m,
  output logic [N-1:0] dt,
  output logic         dda_en,
  output logic         dda_rst_n,
  input  logic [N-1:0] v1,
  input  logic [N-1:0] v2,
  output logic         running
);

  localparam int BPW = N / 8;
  localparam int BCW = $clog2(BPW) + 1;

  // Parser state
  parse_state_t   p_state_reg, p_state_next;
  logic [BCW-1:0] bcnt_reg, bcnt_next;
  logic [2:0]     widx_reg, widx_next;
  logic [N-1:0]   shadow_reg, shadow_next;
  logic [7:0]     phi_reg, phi_next;
  logic [15:0]    period_reg;
  logic           rdy_en_reg;
  logic           wr_commit, run_go, stop_cmd, snap_cmd;
  logic           rx_fire;
  logic [3:0]     opcode;

  // Engine state
  run_state_t     r_state_reg, r_state_next;
  logic [15:0]    wait_reg, wait_next;
  logic           stop_reg, stop_next;
  logic           snap_reg, snap_next;
  logic           loaded_reg;
  logic           ser_load, ser_done;

  logic [NUM_CFG*N-1:0] cfg_bus;

  assign opcode = rx_data[7:4];

  // A SNAP byte waits at the input until the engine is idle so it is never lost.
  assign rx_ready = rdy_en_reg &&
                    !(p_state_reg == P_CMD && rx_valid &&
                      opcode == OP_SNAP && r_state_reg != R_IDLE);
  assign rx_fire  = rx_valid && rx_ready;

  // Input becomes ready on the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) rdy_en_reg <= 1'b0;
    else        rdy_en_reg <= 1'b1;
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_state_reg <= P_CMD;
      bcnt_reg    <= '0;
      widx_reg    <= '0;
      shadow_reg  <= '0;
      phi_reg     <= '0;
    end else begin
      p_state_reg <= p_state_next;
      bcnt_reg    <= bcnt_next;
      widx_reg    <= widx_next;
      shadow_reg  <= shadow_next;
      phi_reg     <= phi_next;
    end
  end

  // Parser next state: decode commands and collect data/period bytes.
  always_comb begin
    p_state_next = p_state_reg;
    bcnt_next    = bcnt_reg;
    widx_next    = widx_reg;
    shadow_next  = shadow_reg;
    phi_next     = phi_reg;
    wr_commit    = 1'b0;
    run_go       = 1'b0;
    stop_cmd     = 1'b0;
    snap_cmd     = 1'b0;
    case (p_state_reg)
      P_CMD: begin
        if (rx_fire) begin
          case (opcode)
            OP_WRITE: begin
              widx_next    = rx_data[2:0];
              bcnt_next    = '0;
              p_state_next = P_WDATA;
            end
            OP_RUN: begin
              bcnt_next    = '0;
              p_state_next = P_PDATA;
            end
            OP_STOP: stop_cmd = 1'b1;
            OP_SNAP: snap_cmd = 1'b1;
            default: ;
          endcase
        end
      end
      P_WDATA: begin
        if (rx_fire) begin
          shadow_next = (shadow_reg << 8) | N'(rx_data);
          if (bcnt_reg == BCW'(BPW - 1)) begin
            wr_commit    = 1'b1;
            p_state_next = P_CMD;
          end else begin
            bcnt_next = bcnt_reg + 1'b1;
          end
        end
      end
      P_PDATA: begin
        if (rx_fire) begin
          if (bcnt_reg == BCW'(1)) begin
            run_go       = 1'b1;
            p_state_next = P_CMD;
          end else begin
            phi_next  = rx_data;
            bcnt_next = bcnt_reg + 1'b1;
          end
        end
      end
      default: p_state_next = P_CMD;
    endcase
  end

  // Period register, replaced whenever a RUN command completes.
  always_ff @(posedge clk) begin
    if (!rst_n)      period_reg <= '0;
    else if (run_go) period_reg <= {phi_reg, rx_data};
  end

  // Configuration bank: each register takes the whole shadow word at once,
  // so the DDA never sees a half-written value. Indices 5..7 match nothing.
  generate
    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : gen_cfg
      logic [N-1:0] cfg_reg;
      // Atomic update of one configuration register.
      always_ff @(posedge clk) begin
        if (!rst_n)
          cfg_reg <= '0;
        else if (wr_commit && widx_reg == 3'(gi))
          cfg_reg <= shadow_next;
      end
      assign cfg_bus[gi*N +: N] = cfg_reg;
    end
  endgenerate

  assign ic1  = cfg_bus[N*REG_IC1 +: N];
  assign ic2  = cfg_bus[N*REG_IC2 +: N];
  assign vk_m = cfg_bus[N*REG_VKM +: N];
  assign vd_m = cfg_bus[N*REG_VDM +: N];
  assign dt   = cfg_bus[N*REG_DT  +: N];

  // Engine state register plus the sticky load-select flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_reg <= R_IDLE;
      wait_reg    <= '0;
      stop_reg    <= 1'b0;
      snap_reg    <= 1'b0;
      loaded_reg  <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      wait_reg    <= wait_next;
      stop_reg    <= stop_next;
      snap_reg    <= snap_next;
      if (r_state_reg == R_LOAD) loaded_reg <= 1'b1;
    end
  end

  // Engine next state: load, capture, send, wait, step.
  always_comb begin
    r_state_next = r_state_reg;
    wait_next    = wait_reg;
    stop_next    = stop_reg;
    snap_next    = snap_reg;
    ser_load     = 1'b0;
    // Stop only matters while active; a new RUN cancels a pending stop.
    if (stop_cmd && r_state_reg != R_IDLE) stop_next = 1'b1;
    if (run_go) stop_next = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (run_go) begin
          r_state_next = R_LOAD;
          snap_next    = 1'b0;
        end else if (snap_cmd) begin
          r_state_next = R_CAP;
          snap_next    = 1'b1;
        end
      end
      R_LOAD: r_state_next = R_CAP;
      R_CAP: begin
        ser_load     = 1'b1;
        r_state_next = R_SEND;
      end
      R_SEND: begin
        if (ser_done) begin
          if (stop_reg || snap_reg) begin
            r_state_next = R_IDLE;
            stop_next    = 1'b0;
            snap_next    = 1'b0;
          end else if (period_reg == 16'd0) begin
            r_state_next = R_STEP;
          end else begin
            r_state_next = R_WAIT;
            wait_next    = '0;
          end
        end
      end
      R_WAIT: begin
        if (stop_reg) begin
          r_state_next = R_IDLE;
          stop_next    = 1'b0;
        end else if ({1'b0, wait_reg} + 17'd1 >= {1'b0, period_reg}) begin
          // >= keeps the wait bounded if the period shrinks mid-count.
          r_state_next = R_STEP;
        end else begin
          wait_next = wait_reg + 16'd1;
        end
      end
      R_STEP: r_state_next = R_CAP;
      default: r_state_next = R_IDLE;
    endcase
  end

  assign dda_en    = (r_state_reg == R_LOAD) || (r_state_reg == R_STEP);
  assign dda_rst_n = loaded_reg;
  assign running   = (r_state_reg != R_IDLE);

  dda_tx_ser #(.N(N)) u_tx_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .frame    ({v1, v2}),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_dda_host_if.sv
// Bench for dda_host_if: byte-level stimulus, a toy DDA core, and a frame
// scoreboard fed from an arithmetic model of the DDA state sequence.
module tb_dda_host_if;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [N-1:0] ic1, ic2, vk_m, vd_m, dt;
  logic         dda_en, dda_rst_n, running;
  logic [N-1:0] v1 = '0;
  logic [N-1:0] v2 = '0;

  int total = 0;
  int bad = 0;

  // Monitor/scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] frame_acc = '0;
  logic [7:0]  stall_data = '0;
  bit   sb_en = 0, spacing_en = 0, have_prev = 0, bp_seen = 0, stall_prev = 0;
  int   cyc = 0, byte_idx = 0, frames_rx = 0, en_cnt = 0, load_cnt = 0, prev_step = 0;

  logic [N-1:0] cfg_model [0:7];

  always #5 clk = ~clk;

  dda_host_if #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ic1(ic1), .ic2(ic2), .vk_m(vk_m), .vd_m(vd_m), .dt(dt),
    .dda_en(dda_en), .dda_rst_n(dda_rst_n),
    .v1(v1), .v2(v2), .running(running)
  );

  // Toy DDA core: load ICs, or advance one deterministic step.
  always @(posedge clk) begin
    if (dda_en) begin
      if (!dda_rst_n) begin
        v1 <= ic1;
        v2 <= ic2;
      end else begin
        v1 <= v1 + 16'h0123;
        v2 <= v2 + v1;
      end
    end
  end

  // Reference: the k-th frame after a load is the k-th iterate of the step.
  function automatic logic [31:0] next_state(input logic [31:0] f);
    return {f[31:16] + 16'h0123, f[15:0] + f[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: frame assembly, scoreboard pops, hold checks, strobe counting.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        byte_idx   = 0;
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
          check("tx_hold_data", {24'd0, tx_data}, {24'd0, stall_data});
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (stall_prev) bp_seen = 1;
        if (tx_valid && tx_ready) begin
          frame_acc = {frame_acc[23:0], tx_data};
          byte_idx++;
          if (byte_idx == 4) begin
            byte_idx = 0;
            frames_rx++;
            if (sb_en) begin
              if (exp_q.size() == 0) begin
                check("frame_unexpected", frame_acc, 32'hxxxx_xxxx);
              end else begin
                check("frame", frame_acc, exp_q.pop_front());
              end
            end
          end
        end
        if (dda_en) begin
          en_cnt++;
          if (!dda_rst_n) begin
            load_cnt++;
          end else begin
            if (spacing_en && have_prev && !bp_seen)
              check("step_spacing", cyc - prev_step, 32'd10);
            prev_step = cyc;
            have_prev = 1;
            bp_seen   = 0;
          end
        end
      end
    end
  end

  // Entered and left at #1 after a posedge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    send_byte({4'h1, 1'b0, idx});
    send_byte(val[15:8]);
    send_byte(val[7:0]);
    cfg_model[idx] = val;
  endtask

  task automatic check_regs(input string name);
    @(negedge clk);
    check({name, "_ic1"}, {16'd0, ic1}, {16'd0, cfg_model[0]});
    check({name, "_ic2"}, {16'd0, ic2}, {16'd0, cfg_model[1]});
    check({name, "_vkm"}, {16'd0, vk_m}, {16'd0, cfg_model[2]});
    check({name, "_vdm"}, {16'd0, vd_m}, {16'd0, cfg_model[3]});
    check({name, "_dt"}, {16'd0, dt}, {16'd0, cfg_model[4]});
    @(posedge clk);
    #1;
  endtask

  // Wait until the frame in flight has delivered k bytes and is still valid.
  task automatic wait_byte_idx(input int k);
    int t = 0;
    while (!(tx_valid && byte_idx == k) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!(tx_valid && byte_idx == k)) check("wait_byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    int e0, f0, n, t;
    logic [2:0] ridx;
    logic [15:0] rval;
    logic [15:0] dt_old;

    for (int i = 0; i < 8; i++) cfg_model[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_dda_en", {31'd0, dda_en}, 32'd0);
    check("rst_dda_rst_n", {31'd0, dda_rst_n}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_regs("rst");

    // Plain writes, then a write to an unused index
    write_reg(3'd0, 16'h4000);
    check_regs("wr_ic1");
    write_reg(3'd6, 16'hAA55);
    check_regs("wr_idx6");
    for (int i = 0; i < 6; i++) begin
      ridx = 3'($urandom_range(2, 7));
      rval = 16'($urandom);
      write_reg(ridx, rval);
      check_regs("wr_rand");
    end
    write_reg(3'd1, 16'h0000);
    check_regs("wr_ic2");

    // RUN with period 4
    f = {16'h4000, 16'h0000};
    for (int k = 0; k < 300; k++) begin
      exp_q.push_back(f);
      f = next_state(f);
    end
    frames_rx  = 0;
    sb_en      = 1;
    spacing_en = 1;
    have_prev  = 0;
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h04);
    wait_cycles(60);
    check("load_pulses", load_cnt, 32'd1);
    check("run_running", {31'd0, running}, 32'd1);
    check("run_dda_rst_n", {31'd0, dda_rst_n}, 32'd1);

    // Backpressure mid-frame
    wait_byte_idx(1);
    tx_ready = 1'b0;
    e0 = en_cnt;
    wait_cycles(30);
    check("bp_no_steps", en_cnt, e0);
    tx_ready = 1'b1;
    f0 = frames_rx;
    wait_cycles(40);
    check("bp_resume_frames", {31'd0, frames_rx > f0}, 32'd1);
    check("bp_resume_steps", {31'd0, en_cnt > e0}, 32'd1);

    // dt write while running
    dt_old = cfg_model[4];
    send_byte(8'h14);
    send_byte(8'h38);
    @(negedge clk);
    check("dt_hold_old", {16'd0, dt}, {16'd0, dt_old});
    @(posedge clk);
    #1;
    send_byte(8'h00);
    cfg_model[4] = 16'h3800;
    @(negedge clk);
    check("dt_new", {16'd0, dt}, 32'h3800);
    @(posedge clk);
    #1;
    wait_cycles(30);

    // Random host backpressure
    repeat (120) begin
      @(posedge clk);
      #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    wait_cycles(30);

    // STOP after two bytes of a frame
    wait_byte_idx(2);
    send_byte(8'h30);
    t = 0;
    while (running && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stop_running", {31'd0, running}, 32'd0);
    check("stop_frame_done", byte_idx, 32'd0);
    e0 = en_cnt;
    n  = frames_rx;
    wait_cycles(20);
    check("stop_no_steps", en_cnt, e0);
    spacing_en = 0;

    // SNAP: one frame of the current state, no strobe
    exp_q.delete();
    f = {16'h4000, 16'h0000};
    for (int k = 0; k < n - 1; k++) f = next_state(f);
    exp_q.push_back(f);
    send_byte(8'h40);
    t = 0;
    while (frames_rx != n + 1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("snap_frames", frames_rx, n + 1);
    wait_cycles(10);
    check("snap_no_steps", en_cnt, e0);
    check("snap_idle", {31'd0, running}, 32'd0);
    check("snap_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-frame and mid-write
    sb_en = 0;
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h02);
    wait_byte_idx(1);
    send_byte(8'h12);
    send_byte(8'h5A);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst2_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst2_dda_rst_n", {31'd0, dda_rst_n}, 32'd0);
    check("rst2_running", {31'd0, running}, 32'd0);
    check("rst2_dda_en", {31'd0, dda_en}, 32'd0);
    for (int i = 0; i < 8; i++) cfg_model[i] = '0;
    @(posedge clk);
    #1;
    check_regs("rst2");
    rst_n = 1'b1;
    wait_cycles(2);
    send_byte(8'h7B);
    wait_cycles(3);
    check_regs("rst2_discard");
    check("rst2_still_idle", {31'd0, running}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
